// File: rtl/lpif_tx_buf.sv
// lpif_tx_buf: transmit-side beat buffer between the link layer and the PHY.
//
// A DEPTH-entry FIFO holds whole beats (data, per-byte valid, and the four
// framing marker vectors). Beats with no valid byte are accepted and dropped.
// A small stall FSM drains the FIFO when the PHY asks to stall, then
// acknowledges. Input is held off for the whole stall handshake.
//
// Ports
//   clk, reset               single clock, synchronous active-high reset
//   lp_data/lp_valid/lp_*    incoming beat and its framing markers
//   lp_irdy / pl_trdy        beat handshake (accepted when both are 1)
//   pl_stall_req             PHY stall request
//   lp_stall_ack             registered stall acknowledge (1 while STALLED)
//   phy_*                    head entry, driven combinationally from storage
//   phy_vld / phy_rdy        head handshake (popped when both are 1)
//   level                    current number of stored entries
module lpif_tx_buf #(
    parameter int NBYTES = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NBYTES*8-1:0]          lp_data,
    input  logic [NBYTES-1:0]            lp_valid,
    input  logic [NBYTES:0]              lp_tlp_start,
    input  logic [NBYTES:0]              lp_tlp_end,
    input  logic [NBYTES:0]              lp_dllp_start,
    input  logic [NBYTES:0]              lp_dllp_end,
    input  logic                         lp_irdy,
    output logic                         pl_trdy,
    input  logic                         pl_stall_req,
    output logic                         lp_stall_ack,
    output logic [NBYTES*8-1:0]          phy_data,
    output logic [NBYTES-1:0]            phy_valid,
    output logic [NBYTES:0]              phy_tlp_start,
    output logic [NBYTES:0]              phy_tlp_end,
    output logic [NBYTES:0]              phy_dllp_start,
    output logic [NBYTES:0]              phy_dllp_end,
    output logic                         phy_vld,
    input  logic                         phy_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_STALLED = 2'd2;

    // Storage is intentionally not reset; only the pointers/level qualify it.
    logic [NBYTES*8-1:0] data_mem [DEPTH];
    logic [NBYTES-1:0]   vld_mem  [DEPTH];
    logic [NBYTES:0]     ts_mem   [DEPTH];
    logic [NBYTES:0]     te_mem   [DEPTH];
    logic [NBYTES:0]     ds_mem   [DEPTH];
    logic [NBYTES:0]     de_mem   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [1:0]    state_q, state_d;
    logic          ack_q, ack_d;

    logic push, pop;

    // Full blocks acceptance even if the head pops this cycle: no push-through.
    assign pl_trdy = !reset && (state_q == ST_RUN) && !pl_stall_req && (level_q < DEPTH_L);
    assign phy_vld = (level_q != '0);

    // Idle beats (no valid byte) complete the handshake but are not stored.
    assign push = lp_irdy && pl_trdy && (|lp_valid);
    assign pop  = phy_vld && phy_rdy;

    assign phy_data       = data_mem[rd_ptr_q];
    assign phy_valid      = vld_mem[rd_ptr_q];
    assign phy_tlp_start  = ts_mem[rd_ptr_q];
    assign phy_tlp_end    = te_mem[rd_ptr_q];
    assign phy_dllp_start = ds_mem[rd_ptr_q];
    assign phy_dllp_end   = de_mem[rd_ptr_q];

    assign level        = level_q;
    assign lp_stall_ack = ack_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        state_d  = state_q;

        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        case (state_q)
            ST_RUN: begin
                if (pl_stall_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Abort wins over completion; empty is judged after this edge's pop.
                if (!pl_stall_req)       state_d = ST_RUN;
                else if (level_d == '0)  state_d = ST_STALLED;
            end
            ST_STALLED: begin
                if (!pl_stall_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase

        // Ack tracks the next state so it is high exactly while in STALLED.
        ack_d = (state_d == ST_STALLED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= ST_RUN;
            ack_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            ack_q    <= ack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= lp_data;
            vld_mem[wr_ptr_q]  <= lp_valid;
            ts_mem[wr_ptr_q]   <= lp_tlp_start;
            te_mem[wr_ptr_q]   <= lp_tlp_end;
            ds_mem[wr_ptr_q]   <= lp_dllp_start;
            de_mem[wr_ptr_q]   <= lp_dllp_end;
        end
    end

endmodule

// File: tb/tb_lpif_tx_buf.sv
// Bench for lpif_tx_buf: a scoreboard queue per instance records every beat
// the driver sees accepted and compares it against the head when it pops.
module tb_lpif_tx_buf;
    localparam int NB  = 8;
    localparam int DP  = 4;
    localparam int NB2 = 16;
    localparam int DP2 = 8;
    localparam int FW  = NB + 1;
    localparam int FW2 = NB2 + 1;

    typedef logic [255:0] vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // instance A: NBYTES=8, DEPTH=4
    logic [NB*8-1:0] lp_data, phy_data;
    logic [NB-1:0]   lp_valid, phy_valid;
    logic [FW-1:0]   lp_ts, lp_te, lp_ds, lp_de, phy_ts, phy_te, phy_ds, phy_de;
    logic lp_irdy, pl_trdy, pl_stall_req, lp_stall_ack, phy_vld, phy_rdy;
    logic [$clog2(DP+1)-1:0] level;

    // instance B: NBYTES=16, DEPTH=8
    logic [NB2*8-1:0] b_lp_data, b_phy_data;
    logic [NB2-1:0]   b_lp_valid, b_phy_valid;
    logic [FW2-1:0]   b_lp_ts, b_lp_te, b_lp_ds, b_lp_de, b_phy_ts, b_phy_te, b_phy_ds, b_phy_de;
    logic b_lp_irdy, b_pl_trdy, b_pl_stall_req, b_lp_stall_ack, b_phy_vld, b_phy_rdy;
    logic [$clog2(DP2+1)-1:0] b_level;

    lpif_tx_buf #(.NBYTES(NB), .DEPTH(DP)) u_dut (
        .clk(clk), .reset(reset),
        .lp_data(lp_data), .lp_valid(lp_valid),
        .lp_tlp_start(lp_ts), .lp_tlp_end(lp_te), .lp_dllp_start(lp_ds), .lp_dllp_end(lp_de),
        .lp_irdy(lp_irdy), .pl_trdy(pl_trdy),
        .pl_stall_req(pl_stall_req), .lp_stall_ack(lp_stall_ack),
        .phy_data(phy_data), .phy_valid(phy_valid),
        .phy_tlp_start(phy_ts), .phy_tlp_end(phy_te), .phy_dllp_start(phy_ds), .phy_dllp_end(phy_de),
        .phy_vld(phy_vld), .phy_rdy(phy_rdy), .level(level)
    );

    lpif_tx_buf #(.NBYTES(NB2), .DEPTH(DP2)) u_dut_b (
        .clk(clk), .reset(reset),
        .lp_data(b_lp_data), .lp_valid(b_lp_valid),
        .lp_tlp_start(b_lp_ts), .lp_tlp_end(b_lp_te), .lp_dllp_start(b_lp_ds), .lp_dllp_end(b_lp_de),
        .lp_irdy(b_lp_irdy), .pl_trdy(b_pl_trdy),
        .pl_stall_req(b_pl_stall_req), .lp_stall_ack(b_lp_stall_ack),
        .phy_data(b_phy_data), .phy_valid(b_phy_valid),
        .phy_tlp_start(b_phy_ts), .phy_tlp_end(b_phy_te), .phy_dllp_start(b_phy_ds), .phy_dllp_end(b_phy_de),
        .phy_vld(b_phy_vld), .phy_rdy(b_phy_rdy), .level(b_level)
    );

    int checks = 0;
    int failures = 0;
    vec_t q0[$];
    vec_t q2[$];

    task automatic chk(input string tag, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic vec_t pk0(input logic [NB*8-1:0] d, input logic [NB-1:0] v,
                                 input logic [FW-1:0] ts, input logic [FW-1:0] te,
                                 input logic [FW-1:0] ds, input logic [FW-1:0] de);
        return vec_t'({de, ds, te, ts, v, d});
    endfunction

    function automatic vec_t pk2(input logic [NB2*8-1:0] d, input logic [NB2-1:0] v,
                                 input logic [FW2-1:0] ts, input logic [FW2-1:0] te,
                                 input logic [FW2-1:0] ds, input logic [FW2-1:0] de);
        return vec_t'({de, ds, te, ts, v, d});
    endfunction

    // scoreboards: compare the head on pop, then record any beat accepted now
    always @(negedge clk) begin
        if (!reset) begin
            if (phy_vld && phy_rdy) begin
                if (q0.size() == 0) chk("a_sb_underflow", vec_t'(1), vec_t'(0));
                else chk("a_beat", pk0(phy_data, phy_valid, phy_ts, phy_te, phy_ds, phy_de), q0.pop_front());
            end
            if (lp_irdy && pl_trdy && (|lp_valid))
                q0.push_back(pk0(lp_data, lp_valid, lp_ts, lp_te, lp_ds, lp_de));
            if (b_phy_vld && b_phy_rdy) begin
                if (q2.size() == 0) chk("b_sb_underflow", vec_t'(1), vec_t'(0));
                else chk("b_beat", pk2(b_phy_data, b_phy_valid, b_phy_ts, b_phy_te, b_phy_ds, b_phy_de), q2.pop_front());
            end
            if (b_lp_irdy && b_pl_trdy && (|b_lp_valid))
                q2.push_back(pk2(b_lp_data, b_lp_valid, b_lp_ts, b_lp_te, b_lp_ds, b_lp_de));
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic rnd_beat0();
        lp_data  = {$urandom(), $urandom()};
        lp_valid = NB'($urandom());
        if (lp_valid == '0) lp_valid = NB'(1);
        lp_ts = FW'($urandom()); lp_te = FW'($urandom());
        lp_ds = FW'($urandom()); lp_de = FW'($urandom());
    endtask

    task automatic rnd_beat2();
        b_lp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        b_lp_valid = NB2'($urandom());
        if (b_lp_valid == '0) b_lp_valid = NB2'(1);
        b_lp_ts = FW2'($urandom()); b_lp_te = FW2'($urandom());
        b_lp_ds = FW2'($urandom()); b_lp_de = FW2'($urandom());
    endtask

    // offer one fresh beat and hold it until accepted; returns at posedge+1
    task automatic offer0();
        rnd_beat0();
        lp_irdy = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (pl_trdy) begin
                step();
                lp_irdy = 1'b0;
                return;
            end
            step();
        end
        chk("offer_timeout", vec_t'(1), vec_t'(0));
        lp_irdy = 1'b0;
    endtask

    task automatic wait_empty0(input string tag);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (level == '0) break;
            step();
        end
        chk(tag, vec_t'(level), vec_t'(0));
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        lp_irdy = 0; pl_stall_req = 0; phy_rdy = 0;
        lp_data = '0; lp_valid = '0; lp_ts = '0; lp_te = '0; lp_ds = '0; lp_de = '0;
        b_lp_irdy = 0; b_pl_stall_req = 0; b_phy_rdy = 0;
        b_lp_data = '0; b_lp_valid = '0; b_lp_ts = '0; b_lp_te = '0; b_lp_ds = '0; b_lp_de = '0;

        // reset state
        step(); step();
        @(negedge clk);
        chk("rst_trdy", vec_t'(pl_trdy), vec_t'(0));
        chk("rst_level", vec_t'(level), vec_t'(0));
        chk("rst_vld", vec_t'(phy_vld), vec_t'(0));
        chk("rst_ack", vec_t'(lp_stall_ack), vec_t'(0));
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_trdy", vec_t'(pl_trdy), vec_t'(1));
        step();

        // streaming with phy_rdy=1: one-cycle latency, level stays <= 1
        phy_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rnd_beat0();
            lp_irdy = 1'b1;
            @(negedge clk);
            chk("s40_trdy", vec_t'(pl_trdy), vec_t'(1));
            chk("s40_level", vec_t'(level), vec_t'((i == 0) ? 0 : 1));
            chk("s40_vld", vec_t'(phy_vld), vec_t'((i == 0) ? 0 : 1));
            step();
        end
        lp_irdy = 1'b0;
        @(negedge clk);
        chk("s40_last_vld", vec_t'(phy_vld), vec_t'(1));
        step();
        @(negedge clk);
        chk("s40_empty", vec_t'(level), vec_t'(0));
        step();

        // idle beat is consumed but not stored
        rnd_beat0();
        lp_valid = '0;
        lp_irdy = 1'b1;
        @(negedge clk);
        chk("idle_trdy", vec_t'(pl_trdy), vec_t'(1));
        step();
        lp_irdy = 1'b0;
        @(negedge clk);
        chk("idle_level", vec_t'(level), vec_t'(0));
        chk("idle_vld", vec_t'(phy_vld), vec_t'(0));
        step();

        // fill to full, no push-through on pop while full, then wrap
        phy_rdy = 1'b0;
        repeat (4) offer0();
        rnd_beat0();
        lp_irdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("full_level", vec_t'(level), vec_t'(DP));
            chk("full_trdy", vec_t'(pl_trdy), vec_t'(0));
            step();
        end
        phy_rdy = 1'b1;
        @(negedge clk);
        chk("full_pop_trdy", vec_t'(pl_trdy), vec_t'(0));
        step();
        lp_irdy = 1'b0;
        offer0();
        offer0();
        wait_empty0("s41_drain");

        // stall with drain: ack after the last pop, release re-enables trdy
        phy_rdy = 1'b0;
        repeat (3) offer0();
        rnd_beat0();
        lp_irdy = 1'b1;
        pl_stall_req = 1'b1;
        phy_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_trdy", vec_t'(pl_trdy), vec_t'(0));
            chk("stall_ack_lo", vec_t'(lp_stall_ack), vec_t'(0));
            chk("stall_level", vec_t'(level), vec_t'(3 - k));
            step();
        end
        @(negedge clk);
        chk("stall_ack_hi", vec_t'(lp_stall_ack), vec_t'(1));
        chk("stall_empty", vec_t'(level), vec_t'(0));
        step();
        pl_stall_req = 1'b0;
        @(negedge clk);
        chk("rel_ack_held", vec_t'(lp_stall_ack), vec_t'(1));
        chk("rel_trdy_held", vec_t'(pl_trdy), vec_t'(0));
        step();
        @(negedge clk);
        chk("rel_ack", vec_t'(lp_stall_ack), vec_t'(0));
        chk("rel_trdy", vec_t'(pl_trdy), vec_t'(1));
        step();
        lp_irdy = 1'b0;
        wait_empty0("rel_drain");

        // aborted stall: one-cycle request pulse, no ack, nothing lost
        phy_rdy = 1'b0;
        repeat (3) offer0();
        pl_stall_req = 1'b1;
        @(negedge clk);
        chk("abort_trdy0", vec_t'(pl_trdy), vec_t'(0));
        step();
        pl_stall_req = 1'b0;
        @(negedge clk);
        chk("abort_drain_trdy", vec_t'(pl_trdy), vec_t'(0));
        chk("abort_ack0", vec_t'(lp_stall_ack), vec_t'(0));
        step();
        @(negedge clk);
        chk("abort_run_trdy", vec_t'(pl_trdy), vec_t'(1));
        chk("abort_ack1", vec_t'(lp_stall_ack), vec_t'(0));
        chk("abort_level", vec_t'(level), vec_t'(3));
        step();
        phy_rdy = 1'b1;
        wait_empty0("abort_drain");

        // reset mid-transfer discards entries; next beat has 1-cycle latency
        phy_rdy = 1'b0;
        repeat (2) offer0();
        @(negedge clk);
        chk("mid_level", vec_t'(level), vec_t'(2));
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_trdy", vec_t'(pl_trdy), vec_t'(0));
        step();
        reset = 1'b0;
        q0.delete();
        q2.delete();
        @(negedge clk);
        chk("mid_rst_level", vec_t'(level), vec_t'(0));
        chk("mid_rst_vld", vec_t'(phy_vld), vec_t'(0));
        chk("mid_rst_ack", vec_t'(lp_stall_ack), vec_t'(0));
        chk("mid_rst_trdy1", vec_t'(pl_trdy), vec_t'(1));
        step();
        phy_rdy = 1'b1;
        rnd_beat0();
        lp_irdy = 1'b1;
        step();
        lp_irdy = 1'b0;
        @(negedge clk);
        chk("mid_new_vld", vec_t'(phy_vld), vec_t'(1));
        chk("mid_new_level", vec_t'(level), vec_t'(1));
        step();
        @(negedge clk);
        chk("mid_new_empty", vec_t'(level), vec_t'(0));
        step();

        // wide/deep instance streaming
        b_phy_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rnd_beat2();
            b_lp_irdy = 1'b1;
            @(negedge clk);
            chk("b_trdy", vec_t'(b_pl_trdy), vec_t'(1));
            chk("b_level", vec_t'(b_level), vec_t'((i == 0) ? 0 : 1));
            chk("b_vld", vec_t'(b_phy_vld), vec_t'((i == 0) ? 0 : 1));
            step();
        end
        b_lp_irdy = 1'b0;
        step();
        @(negedge clk);
        chk("b_empty", vec_t'(b_level), vec_t'(0));
        step();

        chk("a_sb_left", vec_t'(q0.size()), vec_t'(0));
        chk("b_sb_left", vec_t'(q2.size()), vec_t'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lpif_tx_buf.md
LPIF_TX_BUF -- requirements
Module: lpif_tx_buf

Interface
REQ-001 Parameter NBYTES, default 8, bytes per beat; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, FIFO entries; power of 2, at least 2.
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 lp_data  in  NBYTES*8  link-layer transmit data; byte i is bits [8i+7:8i].
REQ-006 lp_valid  in  NBYTES  per-byte valid.
REQ-007 lp_tlp_start, lp_tlp_end, lp_dllp_start, lp_dllp_end  in  NBYTES+1 each  framing markers carried with the beat.
REQ-008 lp_irdy  in  1  beat offered.
REQ-009 pl_trdy  out  1  beat accepted when lp_irdy and pl_trdy are both 1.
REQ-010 pl_stall_req  in  1  PHY stall request.
REQ-011 lp_stall_ack  out  1  stall acknowledge, registered.
REQ-012 phy_data, phy_valid, phy_tlp_start, phy_tlp_end, phy_dllp_start, phy_dllp_end  out  same widths as the lp_ counterparts  head FIFO entry.
REQ-013 phy_vld  out  1  head entry present.
REQ-014 phy_rdy  in  1  pop head when phy_vld and phy_rdy are both 1.
REQ-015 level  out  $clog2(DEPTH+1)  current entry count.

Function
REQ-016 Storage SHALL be a DEPTH-entry FIFO; each entry holds data, valid and all four framing fields of one beat.
REQ-017 An accepted beat with lp_valid all-zero SHALL be consumed and SHALL NOT be written (idle beat).
REQ-018 An accepted beat with any lp_valid bit set SHALL be written at the tail on the accept edge.
REQ-019 Latency: a beat written into an empty FIFO in cycle N SHALL appear on phy_* with phy_vld=1 in cycle N+1.
REQ-020 phy_vld SHALL equal (level != 0); phy_* SHALL show the head entry combinationally from storage.
REQ-021 pl_trdy SHALL equal (state==RUN) && !pl_stall_req && (level < DEPTH); it is combinational in pl_stall_req.
REQ-022 When full, pl_trdy SHALL be 0 even if a pop occurs in the same cycle; there is no same-cycle push-through when full.
REQ-023 Simultaneous push and pop when 0 < level < DEPTH: level SHALL be unchanged and both pointers SHALL advance.
REQ-024 Pointers SHALL wrap modulo DEPTH.
REQ-025 level SHALL never exceed DEPTH or drop below 0; a pop with level==0 is impossible because phy_vld=0.
REQ-026 phy_* and level SHALL stay unaffected by lp_irdy while pl_trdy=0.
REQ-027 Stall FSM states: RUN, DRAIN, STALLED.
REQ-028 RUN->DRAIN on any cycle with pl_stall_req=1.
REQ-029 DRAIN->STALLED when level==0 at the clock edge, counting a pop on that edge.
REQ-030 DRAIN->RUN if pl_stall_req=0 before STALLED is reached (abort); lp_stall_ack SHALL NOT pulse.
REQ-031 STALLED->RUN when pl_stall_req=0.
REQ-032 lp_stall_ack SHALL be 1 exactly while state==STALLED; earliest assertion is 2 cycles after pl_stall_req rises.
REQ-033 During DRAIN and STALLED, popping via phy_rdy SHALL continue normally.
REQ-034 lp_stall_ack SHALL deassert the cycle after pl_stall_req falls; pl_trdy SHALL be re-enabled in that same cycle.

Reset
REQ-035 While reset=1 at an edge: pointers=0, level=0, state=RUN, lp_stall_ack=0.
REQ-036 While reset=1 at an edge, phy_vld=0 and pl_trdy=0 (pl_trdy gated by reset).
REQ-037 FIFO data contents SHALL NOT be reset; phy_data SHALL be don't-care while phy_vld=0.
REQ-038 Reset mid-transfer SHALL discard all entries and abort any stall handshake.
REQ-039 The first beat after reset SHALL be accepted in the cycle after reset falls.

Verification
REQ-040 NBYTES=8, DEPTH=4, phy_rdy=1: send beats D0..D3 one per cycle -> each appears one cycle later on phy_data, in order, level ≤1.
REQ-041 phy_rdy=0, offer 6 beats -> 4 accepted, pl_trdy=0 with level=4; phy_rdy=1 -> remaining 2 accepted once level<4; all 6 exit in order across pointer wrap.
REQ-042 Offer beat with lp_valid=8'h00 -> pl_trdy=1, level stays 0, phy_vld stays 0.
REQ-043 level=3, raise pl_stall_req, phy_rdy=1 -> pl_trdy=0 same cycle; lp_stall_ack=1 after last pop; drop req -> ack=0 and pl_trdy=1 next cycle.
REQ-044 level=3, phy_rdy=0, pulse pl_stall_req for 1 cycle -> DRAIN then RUN, lp_stall_ack never 1, no entry lost.
REQ-045 level=2, assert reset 1 cycle -> level=0, phy_vld=0, lp_stall_ack=0; a new beat then passes with 1-cycle latency; repeat REQ-040 with NBYTES=16, DEPTH=8.
